// File: rtl/header_parser_pkg.sv
// Shared types and helpers for the header capture buffer: FSM state encoding, byte reversal
// between stream order and network order, and beat-index width sizing.
package header_parser_pkg;

  typedef enum logic [2:0] {
    StIdle    = 3'd0,
    StCapture = 3'd1,
    StDecide  = 3'd2,
    StReplay  = 3'd3,
    StPass    = 3'd4,
    StDrop    = 3'd5
  } state_e;

  // Widest beat reverse_bytes can handle; callers zero-extend and truncate around it.
  localparam int unsigned MaxDataWidth = 1024;

  function automatic logic [MaxDataWidth-1:0] reverse_bytes(input logic [MaxDataWidth-1:0] data,
                                                            input int unsigned num_bytes);
    logic [MaxDataWidth-1:0] res;
    res = '0;
    for (int unsigned i = 0; i < MaxDataWidth / 8; i++) begin
      if (i < num_bytes) res[i*8 +: 8] = data[(num_bytes-1-i)*8 +: 8];
    end
    return res;
  endfunction

  function automatic int unsigned beat_idx_width(input int unsigned beats);
    return (beats > 1) ? $clog2(beats) : 1;
  endfunction

endpackage

// File: rtl/hdr_field_extract.sv
// Slices the TCAM key and packet length out of the network-order header buffer; offsets are
// counted from the buffer MSB.
module hdr_field_extract #(
  parameter int unsigned HDR_WIDTH            = 320,
  parameter int unsigned TCAM_KEY_WIDTH       = 96,
  parameter int unsigned TCAM_KEY_OFFSET      = 0,
  parameter int unsigned PACKET_LENGTH_WIDTH  = 16,
  parameter int unsigned PACKET_LENGTH_OFFSET = 128
) (
  input  logic [HDR_WIDTH-1:0]           hdr,
  output logic [TCAM_KEY_WIDTH-1:0]      tcam_key,
  output logic [PACKET_LENGTH_WIDTH-1:0] packet_length
);

  if (TCAM_KEY_OFFSET + TCAM_KEY_WIDTH > HDR_WIDTH) begin : g_key_range_err
    $error("tcam key field exceeds header buffer");
  end
  if (PACKET_LENGTH_OFFSET + PACKET_LENGTH_WIDTH > HDR_WIDTH) begin : g_len_range_err
    $error("packet length field exceeds header buffer");
  end

  assign tcam_key      = hdr[HDR_WIDTH-1-TCAM_KEY_OFFSET -: TCAM_KEY_WIDTH];
  assign packet_length = hdr[HDR_WIDTH-1-PACKET_LENGTH_OFFSET -: PACKET_LENGTH_WIDTH];

  logic unused_hdr;
  assign unused_hdr = ^hdr;

endmodule

// File: rtl/header_capture_buffer.sv
// Captures the first HDR_BEATS beats of a packet in network order, presents key/length for a
// forward/drop decision, then replays and passes through. HDR_CAPTURE_LENGTH_CHECK_EN adds len_err.
module header_capture_buffer
  import header_parser_pkg::*;
#(
  parameter int unsigned AXIS_DATA_WIDTH      = 64,
  parameter int unsigned AXIS_KEEP_WIDTH      = AXIS_DATA_WIDTH / 8,
  parameter int unsigned HDR_BEATS            = 5,
  parameter int unsigned HDR_WIDTH            = HDR_BEATS * AXIS_DATA_WIDTH,
  parameter int unsigned TCAM_KEY_WIDTH       = 96,
  parameter int unsigned TCAM_KEY_OFFSET      = 0,
  parameter int unsigned PACKET_LENGTH_WIDTH  = 16,
  parameter int unsigned PACKET_LENGTH_OFFSET = 128
) (
  input  logic                           clk,
  input  logic                           rst,
  input  logic [AXIS_DATA_WIDTH-1:0]     s_axis_tdata,
  input  logic [AXIS_KEEP_WIDTH-1:0]     s_axis_tkeep,
  input  logic                           s_axis_tvalid,
  output logic                           s_axis_tready,
  input  logic                           s_axis_tlast,
  output logic [AXIS_DATA_WIDTH-1:0]     m_axis_tdata,
  output logic [AXIS_KEEP_WIDTH-1:0]     m_axis_tkeep,
  output logic                           m_axis_tvalid,
  input  logic                           m_axis_tready,
  output logic                           m_axis_tlast,
  output logic                           key_valid,
  output logic [TCAM_KEY_WIDTH-1:0]      tcam_key,
  output logic [PACKET_LENGTH_WIDTH-1:0] packet_length,
  output logic                           hdr_short,
  input  logic                           decision_valid,
  input  logic                           decision_drop,
  output logic                           decision_ready,
  output logic                           len_err
);

  localparam int unsigned IdxW = beat_idx_width(HDR_BEATS);
  localparam logic [IdxW-1:0] LastIdx = IdxW'(HDR_BEATS - 1);
  localparam int unsigned NumBytes = AXIS_DATA_WIDTH / 8;

  if (AXIS_DATA_WIDTH > MaxDataWidth) begin : g_width_err
    $error("AXIS_DATA_WIDTH exceeds reverse_bytes capacity");
  end

  state_e                     state_q, state_d;
  logic [AXIS_DATA_WIDTH-1:0] beat_q [HDR_BEATS];
  logic [AXIS_DATA_WIDTH-1:0] beat_d [HDR_BEATS];
  logic [AXIS_KEEP_WIDTH-1:0] keep_q [HDR_BEATS];
  logic [AXIS_KEEP_WIDTH-1:0] keep_d [HDR_BEATS];
  logic [IdxW-1:0]            idx_q, idx_d, last_idx_q, last_idx_d, rd_idx;
  logic                       short_q, short_d, key_valid_q, key_valid_d;
  logic [AXIS_DATA_WIDTH-1:0] m_tdata_q, m_tdata_d, s_rev, rd_data;
  logic [AXIS_KEEP_WIDTH-1:0] m_tkeep_q, m_tkeep_d;
  logic                       m_tvalid_q, m_tvalid_d, m_tlast_q, m_tlast_d;
  logic                       s_tready_int, s_hs, m_hs, dec_hs;
  logic [HDR_WIDTH-1:0]       hdr_flat;

  assign s_rev = AXIS_DATA_WIDTH'(reverse_bytes(MaxDataWidth'(s_axis_tdata), NumBytes));
  // Next replay beat: beat 0 when leaving DECIDE, otherwise the one after the current.
  assign rd_idx  = (state_q == StReplay && idx_q != LastIdx) ? idx_q + 1'b1 : '0;
  assign rd_data = AXIS_DATA_WIDTH'(reverse_bytes(MaxDataWidth'(beat_q[rd_idx]), NumBytes));

  assign s_hs   = s_axis_tvalid && s_tready_int;
  assign m_hs   = m_axis_tvalid && m_axis_tready;
  assign dec_hs = decision_valid && key_valid_q;

  always_comb begin
    state_d      = state_q;
    beat_d       = beat_q;
    keep_d       = keep_q;
    idx_d        = idx_q;
    last_idx_d   = last_idx_q;
    short_d      = short_q;
    key_valid_d  = key_valid_q;
    m_tdata_d    = m_tdata_q;
    m_tkeep_d    = m_tkeep_q;
    m_tvalid_d   = m_tvalid_q;
    m_tlast_d    = m_tlast_q;
    s_tready_int = 1'b0;
    unique case (state_q)
      StIdle: begin
        s_tready_int = 1'b1;
        if (s_hs) begin
          for (int i = 0; i < int'(HDR_BEATS); i++) begin
            beat_d[i] = '0;
            keep_d[i] = '0;
          end
          beat_d[0] = s_rev;
          keep_d[0] = s_axis_tkeep;
          short_d   = s_axis_tlast;
          if (s_axis_tlast || HDR_BEATS == 1) begin
            state_d     = StDecide;
            key_valid_d = 1'b1;
            last_idx_d  = '0;
            idx_d       = '0;
          end else begin
            state_d = StCapture;
            idx_d   = IdxW'(1);
          end
        end
      end
      StCapture: begin
        s_tready_int = 1'b1;
        if (s_hs) begin
          beat_d[idx_q] = s_rev;
          keep_d[idx_q] = s_axis_tkeep;
          short_d       = s_axis_tlast;
          if (s_axis_tlast || idx_q == LastIdx) begin
            state_d     = StDecide;
            key_valid_d = 1'b1;
            last_idx_d  = idx_q;
            idx_d       = '0;
          end else begin
            idx_d = idx_q + 1'b1;
          end
        end
      end
      StDecide: begin
        if (dec_hs) begin
          key_valid_d = 1'b0;
          if (decision_drop) begin
            state_d = short_q ? StIdle : StDrop;
          end else begin
            state_d    = StReplay;
            idx_d      = '0;
            m_tvalid_d = 1'b1;
            m_tdata_d  = rd_data;
            m_tkeep_d  = keep_q[0];
            m_tlast_d  = short_q && (last_idx_q == '0);
          end
        end
      end
      StReplay: begin
        if (m_hs) begin
          if (idx_q == last_idx_q) begin
            m_tvalid_d = 1'b0;
            m_tlast_d  = 1'b0;
            state_d    = short_q ? StIdle : StPass;
          end else begin
            idx_d     = rd_idx;
            m_tdata_d = rd_data;
            m_tkeep_d = keep_q[rd_idx];
            m_tlast_d = short_q && (rd_idx == last_idx_q);
          end
        end
      end
      StPass: begin
        s_tready_int = m_axis_tready;
        if (s_hs && s_axis_tlast) state_d = StIdle;
      end
      StDrop: begin
        s_tready_int = 1'b1;
        if (s_hs && s_axis_tlast) state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= StIdle;
      for (int i = 0; i < int'(HDR_BEATS); i++) begin
        beat_q[i] <= '0;
        keep_q[i] <= '0;
      end
      idx_q       <= '0;
      last_idx_q  <= '0;
      short_q     <= 1'b0;
      key_valid_q <= 1'b0;
      m_tdata_q   <= '0;
      m_tkeep_q   <= '0;
      m_tvalid_q  <= 1'b0;
      m_tlast_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      beat_q      <= beat_d;
      keep_q      <= keep_d;
      idx_q       <= idx_d;
      last_idx_q  <= last_idx_d;
      short_q     <= short_d;
      key_valid_q <= key_valid_d;
      m_tdata_q   <= m_tdata_d;
      m_tkeep_q   <= m_tkeep_d;
      m_tvalid_q  <= m_tvalid_d;
      m_tlast_q   <= m_tlast_d;
    end
  end

  for (genvar i = 0; i < int'(HDR_BEATS); i++) begin : g_flat
    assign hdr_flat[HDR_WIDTH-1-i*AXIS_DATA_WIDTH -: AXIS_DATA_WIDTH] = beat_q[i];
  end

  hdr_field_extract #(
    .HDR_WIDTH            (HDR_WIDTH),
    .TCAM_KEY_WIDTH       (TCAM_KEY_WIDTH),
    .TCAM_KEY_OFFSET      (TCAM_KEY_OFFSET),
    .PACKET_LENGTH_WIDTH  (PACKET_LENGTH_WIDTH),
    .PACKET_LENGTH_OFFSET (PACKET_LENGTH_OFFSET)
  ) u_extract (
    .hdr           (hdr_flat),
    .tcam_key      (tcam_key),
    .packet_length (packet_length)
  );

  // PASS is a wire-through; every other state drives the registered replay beat.
  assign s_axis_tready  = s_tready_int;
  assign m_axis_tvalid  = (state_q == StPass) ? s_axis_tvalid : m_tvalid_q;
  assign m_axis_tdata   = (state_q == StPass) ? s_axis_tdata  : m_tdata_q;
  assign m_axis_tkeep   = (state_q == StPass) ? s_axis_tkeep  : m_tkeep_q;
  assign m_axis_tlast   = (state_q == StPass) ? s_axis_tlast  : m_tlast_q;
  assign key_valid      = key_valid_q;
  assign decision_ready = key_valid_q;
  assign hdr_short      = short_q;

`ifdef HDR_CAPTURE_LENGTH_CHECK_EN
  logic [PACKET_LENGTH_WIDTH-1:0] byte_cnt_q, byte_cnt_d, beat_bytes, len_next;
  logic [HDR_WIDTH-1:0]           hdr_next;

  // A short packet ends during capture, so compare against the buffer including this beat.
  for (genvar i = 0; i < int'(HDR_BEATS); i++) begin : g_flat_next
    assign hdr_next[HDR_WIDTH-1-i*AXIS_DATA_WIDTH -: AXIS_DATA_WIDTH] = beat_d[i];
  end
  assign len_next = hdr_next[HDR_WIDTH-1-PACKET_LENGTH_OFFSET -: PACKET_LENGTH_WIDTH];

  logic unused_hdr_next;
  assign unused_hdr_next = ^hdr_next;

  always_comb begin
    beat_bytes = '0;
    for (int i = 0; i < int'(AXIS_KEEP_WIDTH); i++) begin
      beat_bytes = beat_bytes + PACKET_LENGTH_WIDTH'(s_axis_tkeep[i]);
    end
    byte_cnt_d = byte_cnt_q;
    if (s_hs) byte_cnt_d = s_axis_tlast ? '0 : byte_cnt_q + beat_bytes;
  end

  always_ff @(posedge clk) begin
    if (rst) byte_cnt_q <= '0;
    else     byte_cnt_q <= byte_cnt_d;
  end

  assign len_err = s_hs && s_axis_tlast && ((byte_cnt_q + beat_bytes) != len_next);
`else
  assign len_err = 1'b0;
`endif

endmodule

// File: tb/tb_header_capture_buffer.sv
// Randomised self-checking bench for header_capture_buffer against a packet-level reference model.
module tb_header_capture_buffer;

  localparam int DW = 64, KW = 8, HB = 5, HW = HB * DW;
  localparam int TKW = 96, TKO = 0, PLW = 16, PLO = 128;

  logic           clk = 1'b0;
  logic           rst;
  logic [DW-1:0]  s_tdata, m_tdata;
  logic [KW-1:0]  s_tkeep, m_tkeep;
  logic           s_tvalid, s_tready, s_tlast, m_tvalid, m_tready, m_tlast;
  logic           key_valid, hdr_short, decision_valid, decision_drop, decision_ready, len_err;
  logic [TKW-1:0] tcam_key;
  logic [PLW-1:0] packet_length;

  always #5 clk = ~clk;

  header_capture_buffer dut (
    .clk            (clk),
    .rst            (rst),
    .s_axis_tdata   (s_tdata),
    .s_axis_tkeep   (s_tkeep),
    .s_axis_tvalid  (s_tvalid),
    .s_axis_tready  (s_tready),
    .s_axis_tlast   (s_tlast),
    .m_axis_tdata   (m_tdata),
    .m_axis_tkeep   (m_tkeep),
    .m_axis_tvalid  (m_tvalid),
    .m_axis_tready  (m_tready),
    .m_axis_tlast   (m_tlast),
    .key_valid      (key_valid),
    .tcam_key       (tcam_key),
    .packet_length  (packet_length),
    .hdr_short      (hdr_short),
    .decision_valid (decision_valid),
    .decision_drop  (decision_drop),
    .decision_ready (decision_ready),
    .len_err        (len_err)
  );

  int n_cmp = 0, n_bad = 0;

  task automatic check_val(input string tag, input logic [127:0] got, input logic [127:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
    end
  endtask

  // Current packet and its expected results.
  logic [DW-1:0]  pkt_data[$];
  logic [KW-1:0]  pkt_keep[$];
  logic [TKW-1:0] exp_key, t1_key;
  logic [PLW-1:0] exp_len;
  bit             exp_short, exp_lerr, t1_chk, drv_done;

  task automatic make_packet(input int nb, input int last_bytes);
    logic [DW-1:0] d;
    logic [KW-1:0] k;
    pkt_data.delete();
    pkt_keep.delete();
    for (int i = 0; i < nb; i++) begin
      d = {$urandom, $urandom};
      k = (i == nb - 1) ? KW'((1 << last_bytes) - 1) : '1;
      for (int j = 0; j < KW; j++) if (!k[j]) d[8*j +: 8] = 8'h00;
      pkt_data.push_back(d);
      pkt_keep.push_back(k);
    end
  endtask

  // Network-order header: wire byte n of the packet lands at bit HW-1-8n.
  task automatic build_model();
    logic [HW-1:0] hdr;
    int total;
    hdr = '0;
    total = 0;
    for (int i = 0; i < pkt_data.size() && i < HB; i++)
      for (int j = 0; j < KW; j++) hdr[HW-1-8*(i*KW+j) -: 8] = pkt_data[i][8*j +: 8];
    foreach (pkt_keep[i]) total += $countones(pkt_keep[i]);
    exp_key   = hdr[HW-1-TKO -: TKW];
    exp_len   = hdr[HW-1-PLO -: PLW];
    exp_short = (pkt_data.size() <= HB);
`ifdef HDR_CAPTURE_LENGTH_CHECK_EN
    exp_lerr  = (PLW'(total) != exp_len);
`else
    exp_lerr  = 1'b0;
`endif
  endtask

  task automatic drive_packet();
    for (int i = 0; i < pkt_data.size(); i++) begin
      int guard = 0;
      bit done = 0;
      if ($urandom_range(3) == 0) begin
        s_tvalid = 1'b0;
        @(negedge clk);
      end
      s_tdata  = pkt_data[i];
      s_tkeep  = pkt_keep[i];
      s_tlast  = (i == pkt_data.size() - 1);
      s_tvalid = 1'b1;
      while (!done) begin
        #1;
        if (s_tready) begin
          done = 1;
          if (s_tlast) check_val("len_err_at_tlast", len_err, exp_lerr);
        end
        @(negedge clk);
        if (!done && ++guard > 1000) begin
          check_val("s_handshake_timeout", 0, 1);
          break;
        end
      end
    end
    s_tvalid = 1'b0;
    s_tlast  = 1'b0;
    drv_done = 1'b1;
  endtask

  task automatic decide(input bit drop);
    int guard = 0;
    // Noise decisions before key_valid must be ignored.
    while (!key_valid && guard < 2000) begin
      decision_valid = 1'($urandom_range(1));
      decision_drop  = 1'b1;
      @(negedge clk);
      guard++;
    end
    decision_valid = 1'b0;
    check_val("key_valid_seen", key_valid, 1);
    check_val("tcam_key", tcam_key, exp_key);
    check_val("packet_length", packet_length, exp_len);
    check_val("hdr_short", hdr_short, exp_short);
    check_val("decision_ready", decision_ready, 1);
    if (t1_chk) check_val("t1_key_const", tcam_key, t1_key);
    repeat ($urandom_range(2)) @(negedge clk);
    check_val("key_valid_held", key_valid, 1);
    decision_valid = 1'b1;
    decision_drop  = drop;
    @(negedge clk);
    decision_valid = 1'b0;
    decision_drop  = 1'b0;
    check_val("key_valid_cleared", key_valid, 0);
  endtask

  task automatic collect_packet(input bit fwd, input bit toggle);
    int idx = 0, guard = 0;
    bit stall = 0;
    logic [DW-1:0] pd;
    logic [KW-1:0] pk;
    if (fwd) begin
      while (idx < pkt_data.size() && guard < 3000) begin
        m_tready = toggle ? 1'(guard % 2 == 0) : 1'($urandom_range(1));
        #1;
        if (stall) begin
          check_val("stall_valid", m_tvalid, 1);
          check_val("stall_data", m_tdata, pd);
          check_val("stall_keep", m_tkeep, pk);
        end
        if (m_tvalid && m_tready) begin
          check_val("out_data", m_tdata, pkt_data[idx]);
          check_val("out_keep", m_tkeep, pkt_keep[idx]);
          check_val("out_last", m_tlast, idx == pkt_data.size() - 1);
          idx++;
          stall = 0;
        end else begin
          stall = m_tvalid;
          pd = m_tdata;
          pk = m_tkeep;
        end
        @(negedge clk);
        guard++;
      end
      check_val("out_beat_count", idx, pkt_data.size());
    end else begin
      while (!drv_done && guard < 3000) begin
        m_tready = 1'($urandom_range(1));
        #1;
        check_val("drop_no_valid", m_tvalid, 0);
        @(negedge clk);
        guard++;
      end
      check_val("drop_all_accepted", drv_done, 1);
    end
    m_tready = 1'b0;
  endtask

  task automatic run_packet(input bit drop, input bit toggle);
    build_model();
    drv_done = 1'b0;
    fork
      drive_packet();
      decide(drop);
      collect_packet(!drop, toggle);
    join
    @(negedge clk);
    #1;
    check_val("idle_tready", s_tready, 1);
    check_val("idle_tvalid", m_tvalid, 0);
    check_val("idle_key_valid", key_valid, 0);
  endtask

  initial begin
    rst = 1'b1;
    s_tdata = '0; s_tkeep = '0; s_tvalid = 1'b0; s_tlast = 1'b0;
    m_tready = 1'b0; decision_valid = 1'b0; decision_drop = 1'b0;
    t1_chk = 1'b0; t1_key = '0;
    repeat (3) @(negedge clk);
    #1;
    check_val("rst_m_tvalid", m_tvalid, 0);
    check_val("rst_key_valid", key_valid, 0);
    check_val("rst_hdr_short", hdr_short, 0);
    check_val("rst_tcam_key", tcam_key, 0);
    check_val("rst_len", packet_length, 0);
    check_val("rst_len_err", len_err, 0);
    rst = 1'b0;
    @(negedge clk);

    // 1) 8-beat forward with known header bytes.
    make_packet(8, 8);
    for (int i = 0; i < 8; i++) pkt_data[i] = 64'h0011_2233_4455_6677 ^ {8{8'(i)}};
    t1_key = 96'h7766_5544_3322_1100_7667_5445;
    t1_chk = 1'b1;
    run_packet(1'b0, 1'b0);
    t1_chk = 1'b0;

    // 2) 2-beat short packet, last tkeep 0x0F.
    make_packet(2, 4);
    run_packet(1'b0, 1'b0);

    // 3) 10-beat drop.
    make_packet(10, 8);
    run_packet(1'b1, 1'b0);

    // 4) toggling m_tready through replay and pass.
    make_packet(9, 3);
    run_packet(1'b0, 1'b1);

    // 5) reset after beat 2 of capture, then a clean packet.
    make_packet(8, 8);
    for (int i = 0; i < 3; i++) begin
      s_tdata = pkt_data[i]; s_tkeep = pkt_keep[i]; s_tlast = 1'b0; s_tvalid = 1'b1;
      @(negedge clk);
    end
    s_tvalid = 1'b0;
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    #1;
    check_val("abort_m_tvalid", m_tvalid, 0);
    check_val("abort_key_valid", key_valid, 0);
    check_val("abort_tcam_key", tcam_key, 0);
    check_val("abort_len", packet_length, 0);
    check_val("abort_tready", s_tready, 1);
    @(negedge clk);
    make_packet(7, 5);
    run_packet(1'b0, 1'b0);

    // 6) length field 0x0040 vs 64 bytes, then 0x0041.
    make_packet(8, 8);
    pkt_data[2][15:0] = 16'h4000;
    run_packet(1'b0, 1'b0);
    make_packet(8, 8);
    pkt_data[2][15:0] = 16'h4100;
    run_packet(1'b1, 1'b0);

    // Random packets.
    for (int n = 0; n < 25; n++) begin
      make_packet($urandom_range(10, 1), $urandom_range(8, 1));
      run_packet(1'($urandom_range(1)), 1'b0);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
